// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port between a CPU and a DMA/debug requester.
// Each access runs IDLE -> ISSUE -> RESP; the CPU has priority, bounded by a burst counter.
module data_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_readdata,
    input  logic              dma_read,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [DATA_W-1:0] dma_writedata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_readdata,
    output logic [ADDR_W-1:0] data_address,
    output logic [DATA_W-1:0] data_writedata,
    output logic              data_read,
    output logic              data_write,
    input  logic [DATA_W-1:0] data_readdata,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_dma_q, grant_dma_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic cpu_pend, dma_pend, win_dma;

    assign cpu_pend = cpu_read | cpu_write;
    assign dma_pend = dma_read | dma_write;
    // DMA only beats a pending CPU once the CPU has used up its burst allowance.
    assign win_dma  = dma_pend & (~cpu_pend | (burst_q == BURST_MAX));

    always_comb begin
        state_d     = state_q;
        grant_dma_d = grant_dma_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        burst_d     = burst_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        if (clk_enable) begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_pend | dma_pend) begin
                        grant_dma_d = win_dma;
                        op_write_d  = win_dma ? dma_write : cpu_write;
                        addr_d      = win_dma ? dma_address : cpu_address;
                        wdata_d     = win_dma ? dma_writedata : cpu_writedata;
                        if (win_dma || !dma_pend) begin
                            burst_d = '0;
                        end else if (burst_q != BURST_MAX) begin
                            burst_d = burst_q + CNT_W'(1);
                        end
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: state_d = S_RESP;
                S_RESP: begin
                    if (!op_write_q) begin
                        if (grant_dma_q) dma_rdata_d = data_readdata;
                        else             cpu_rdata_d = data_readdata;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_dma_q <= 1'b0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            burst_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_dma_q <= grant_dma_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            burst_q     <= burst_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Strobes and acks are gated by clk_enable so a frozen ISSUE/RESP shows nothing.
    assign data_read      = clk_enable & (state_q == S_ISSUE) & ~op_write_q;
    assign data_write     = clk_enable & (state_q == S_ISSUE) & op_write_q;
    assign cpu_ack        = clk_enable & (state_q == S_RESP) & ~grant_dma_q;
    assign dma_ack        = clk_enable & (state_q == S_RESP) & grant_dma_q;
    assign data_address   = addr_q;
    assign data_writedata = wdata_q;
    assign cpu_readdata   = cpu_rdata_q;
    assign dma_readdata   = dma_rdata_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a synchronous-read memory model.
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_address = '0, cpu_writedata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_readdata;
  logic        dma_read = 1'b0, dma_write = 1'b0;
  logic [31:0] dma_address = '0, dma_writedata = '0;
  logic        dma_ack;
  logic [31:0] dma_readdata;
  logic [31:0] data_address, data_writedata;
  logic        data_read, data_write;
  logic [31:0] data_readdata;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem [0:255];
  logic [31:0] mem_rdata;
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_ack(cpu_ack), .cpu_readdata(cpu_readdata),
    .dma_read(dma_read), .dma_write(dma_write), .dma_address(dma_address),
    .dma_writedata(dma_writedata), .dma_ack(dma_ack), .dma_readdata(dma_readdata),
    .data_address(data_address), .data_writedata(data_writedata),
    .data_read(data_read), .data_write(data_write), .data_readdata(data_readdata),
    .dbg_state(dbg_state)
  );

  // Memory: read data appears the cycle after data_read.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (data_write) mem[data_address[7:0]] <= data_writedata;
    if (data_read) mem_rdata <= mem[data_address[7:0]];
  end
  assign data_readdata = mem_rdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic drop_all();
    cpu_read = 1'b0; cpu_write = 1'b0;
    dma_read = 1'b0; dma_write = 1'b0;
  endtask

  // Called at a negedge with the arbiter in IDLE; returns at the negedge of the next IDLE.
  task automatic run_access(input bit is_dma, input bit rd_en, input bit wr_en,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output logic [31:0] rd);
    lat = -1;
    if (is_dma) begin
      dma_read = rd_en; dma_write = wr_en; dma_address = a; dma_writedata = wd;
    end else begin
      cpu_read = rd_en; cpu_write = wr_en; cpu_address = a; cpu_writedata = wd;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((is_dma ? dma_ack : cpu_ack) === 1'b1) begin
        lat = i;
        break;
      end
    end
    drop_all();
    @(negedge clk);
    rd = is_dma ? dma_readdata : cpu_readdata;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clk_enable = 1'($urandom_range(1, 0));
      cpu_read = 1'($urandom_range(1, 0)); cpu_write = 1'($urandom_range(1, 0));
      dma_read = 1'($urandom_range(1, 0)); dma_write = 1'($urandom_range(1, 0));
      cpu_address = $urandom; cpu_writedata = $urandom;
      dma_address = $urandom; dma_writedata = $urandom;
      #1;
      n_vec++;
      if ({data_read, data_write, cpu_ack, dma_ack} !== 4'b0) begin
        $display("FAIL reset_strobes: got %b want 0000", {data_read, data_write, cpu_ack, dma_ack});
        n_bad++;
      end
      n_vec++;
      if ({data_address, data_writedata, cpu_readdata, dma_readdata} !== 128'b0) begin
        $display("FAIL reset_data: got %h %h %h %h want all 0",
                 data_address, data_writedata, cpu_readdata, dma_readdata);
        n_bad++;
      end
    end
    @(negedge clk);
    drop_all();
    cpu_address = '0; dma_address = '0; cpu_writedata = '0; dma_writedata = '0;
    clk_enable = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vec++;
      if ({data_read, data_write} !== 2'b00 || dbg_state !== 2'd0) begin
        $display("FAIL idle_no_strobe: got rd=%b wr=%b st=%0d want 0 0 0", data_read, data_write, dbg_state);
        n_bad++;
      end
    end
  endtask

  task automatic test_cpu_read();
    preload(8'h10, 32'hDEADBEEF);
    cpu_read = 1'b1; cpu_address = 32'h10;
    @(negedge clk);
    n_vec++;
    if (data_read !== 1'b1 || data_write !== 1'b0 || data_address !== 32'h10 || cpu_ack !== 1'b0 || dbg_state !== 2'd1) begin
      $display("FAIL cpu_read_issue: got rd=%b wr=%b addr=%h ack=%b st=%0d want 1 0 00000010 0 1",
               data_read, data_write, data_address, cpu_ack, dbg_state);
      n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (cpu_ack !== 1'b1 || dma_ack !== 1'b0 || data_read !== 1'b0) begin
      $display("FAIL cpu_read_resp: got cpu_ack=%b dma_ack=%b rd=%b want 1 0 0", cpu_ack, dma_ack, data_read);
      n_bad++;
    end
    drop_all();
    @(negedge clk);
    n_vec++;
    if (cpu_readdata !== 32'hDEADBEEF || cpu_ack !== 1'b0) begin
      $display("FAIL cpu_read_data: got %h ack=%b want deadbeef 0", cpu_readdata, cpu_ack);
      n_bad++;
    end
  endtask

  task automatic test_dma_write_cpu_read();
    int lat;
    int extra;
    logic [31:0] rd;
    run_access(1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, lat, rd);
    n_vec++;
    if (lat !== 2) begin
      $display("FAIL dma_write_latency: got %0d want 2", lat);
      n_bad++;
    end
    n_vec++;
    if (rd !== 32'h0) begin
      $display("FAIL dma_write_readdata_held: got %h want 00000000", rd);
      n_bad++;
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (dma_ack === 1'b1) extra++;
      @(negedge clk);
    end
    n_vec++;
    if (extra + ((lat > 0) ? 1 : 0) !== 1) begin
      $display("FAIL dma_ack_once: got %0d pulses want 1", extra + ((lat > 0) ? 1 : 0));
      n_bad++;
    end
    run_access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, rd);
    n_vec++;
    if (lat !== 2 || rd !== 32'h12345678) begin
      $display("FAIL cpu_read_after_dma: got lat=%0d data=%h want 2 12345678", lat, rd);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    // read+write both high must act as a write
    run_access(1'b0, 1'b1, 1'b1, 32'h40, 32'h11112222, lat, rd);
    n_vec++;
    if (lat !== 2 || rd !== 32'h12345678) begin
      $display("FAIL b2b_rw_write: got lat=%0d readdata=%h want 2 12345678", lat, rd);
      n_bad++;
    end
    run_access(1'b0, 1'b0, 1'b1, 32'h44, 32'h33334444, lat, rd);
    n_vec++;
    if (lat !== 2) begin
      $display("FAIL b2b_write2: got lat=%0d want 2", lat);
      n_bad++;
    end
    run_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, lat, rd);
    n_vec++;
    if (lat !== 2 || rd !== 32'h11112222) begin
      $display("FAIL b2b_read40: got lat=%0d data=%h want 2 11112222", lat, rd);
      n_bad++;
    end
    run_access(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, lat, rd);
    n_vec++;
    if (lat !== 2 || rd !== 32'h33334444) begin
      $display("FAIL b2b_read44: got lat=%0d data=%h want 2 33334444", lat, rd);
      n_bad++;
    end
  endtask

  task automatic test_contention();
    int cpu_c, dma_c, both;
    cpu_c = -1; dma_c = -1; both = 0;
    cpu_read = 1'b1; cpu_address = 32'h10;
    dma_read = 1'b1; dma_address = 32'h20;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1 && dma_ack === 1'b1) both++;
      if (cpu_ack === 1'b1) begin cpu_c = c; cpu_read = 1'b0; end
      if (dma_ack === 1'b1) begin dma_c = c; dma_read = 1'b0; end
    end
    drop_all();
    n_vec++;
    if (cpu_c !== 2 || dma_c !== 5 || both !== 0) begin
      $display("FAIL contention_order: got cpu@%0d dma@%0d both=%0d want cpu@2 dma@5 both=0", cpu_c, dma_c, both);
      n_bad++;
    end
    n_vec++;
    if (cpu_readdata !== 32'hDEADBEEF || dma_readdata !== 32'h12345678) begin
      $display("FAIL contention_data: got cpu=%h dma=%h want deadbeef 12345678", cpu_readdata, dma_readdata);
      n_bad++;
    end
  endtask

  task automatic test_burst();
    logic [5:0] who;
    int n_ack, dma_c;
    who = '0; n_ack = 0; dma_c = -1;
    cpu_read = 1'b1; cpu_address = 32'h20;
    dma_read = 1'b1; dma_address = 32'h10;
    for (int c = 1; c <= 40 && n_ack < 6; c++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        n_ack++;
        if (n_ack == 6) cpu_read = 1'b0;
      end else if (dma_ack === 1'b1) begin
        who[n_ack] = 1'b1;
        n_ack++;
        dma_c = c;
        dma_read = 1'b0;
      end
    end
    drop_all();
    @(negedge clk);
    n_vec++;
    if (n_ack !== 6 || who !== 6'b010000) begin
      $display("FAIL burst_grant_order: got acks=%0d pattern=%b want 6 010000", n_ack, who);
      n_bad++;
    end
    n_vec++;
    if (dma_c !== 14) begin
      $display("FAIL burst_dma_cycle: got %0d want 14", dma_c);
      n_bad++;
    end
    n_vec++;
    if (dma_readdata !== 32'hDEADBEEF || cpu_readdata !== 32'h12345678) begin
      $display("FAIL burst_data: got dma=%h cpu=%h want deadbeef 12345678", dma_readdata, cpu_readdata);
      n_bad++;
    end
  endtask

  task automatic test_clk_enable();
    int strobes, acks, frozen_bad;
    strobes = 0; acks = 0; frozen_bad = 0;
    cpu_read = 1'b1; cpu_address = 32'h10;
    @(negedge clk);
    n_vec++;
    if (data_read !== 1'b1) begin
      $display("FAIL ce_issue: got rd=%b want 1", data_read);
      n_bad++;
    end
    clk_enable = 1'b0;
    #1;
    if (data_read !== 1'b0 || data_write !== 1'b0 || cpu_ack !== 1'b0) frozen_bad++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (data_read !== 1'b0 || data_write !== 1'b0 || cpu_ack !== 1'b0 || dma_ack !== 1'b0) frozen_bad++;
    end
    n_vec++;
    if (frozen_bad !== 0) begin
      $display("FAIL ce_frozen_quiet: got %0d active samples want 0", frozen_bad);
      n_bad++;
    end
    clk_enable = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (data_read === 1'b1) strobes++;
      if (cpu_ack === 1'b1) begin acks++; cpu_read = 1'b0; end
      @(negedge clk);
      #1;
    end
    drop_all();
    n_vec++;
    if (strobes !== 1 || acks !== 1) begin
      $display("FAIL ce_resume: got strobes=%0d acks=%0d want 1 1", strobes, acks);
      n_bad++;
    end
    n_vec++;
    if (cpu_readdata !== 32'hDEADBEEF) begin
      $display("FAIL ce_data: got %h want deadbeef", cpu_readdata);
      n_bad++;
    end
  endtask

  task automatic test_reset_midop();
    int lat, acks;
    logic [31:0] rd;
    acks = 0;
    @(negedge clk);
    dma_read = 1'b1; dma_address = 32'h20;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (dma_ack !== 1'b1) begin
      $display("FAIL midop_resp: got dma_ack=%b want 1", dma_ack);
      n_bad++;
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (dma_ack !== 1'b0 || dma_readdata !== 32'h0 || cpu_readdata !== 32'h0) begin
      $display("FAIL midop_reset: got ack=%b dma_rd=%h cpu_rd=%h want 0 0 0", dma_ack, dma_readdata, cpu_readdata);
      n_bad++;
    end
    @(negedge clk);
    drop_all();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dma_ack === 1'b1) acks++;
    end
    n_vec++;
    if (acks !== 0 || dma_readdata !== 32'h0) begin
      $display("FAIL midop_after: got acks=%0d dma_rd=%h want 0 0", acks, dma_readdata);
      n_bad++;
    end
    run_access(1'b0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, lat, rd);
    n_vec++;
    if (lat !== 2) begin
      $display("FAIL midop_cpu_write: got lat=%0d want 2", lat);
      n_bad++;
    end
    run_access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, lat, rd);
    n_vec++;
    if (lat !== 2 || rd !== 32'hCAFEF00D) begin
      $display("FAIL midop_readback: got lat=%0d data=%h want 2 cafef00d", lat, rd);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write_cpu_read();
    test_back_to_back();
    test_contention();
    test_burst();
    test_clk_enable();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single data-memory port (the `data_memory` block's address/read/write/writedata/readdata interface) between the CPU data port and a DMA/debug loader port. It sits between `mips_cpu_harvard` and `data_memory`, sequences each access through a fixed three-state handshake, and returns read data to the winning requester. The CPU has fixed priority, bounded by a starvation counter that guarantees the DMA port a slot.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_BURST`, 4, consecutive CPU grants allowed while DMA waits (≥1)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clk_enable`  in  1  when 0, all state frozen and memory strobes forced 0
- `cpu_read`, `cpu_write`  in  1  CPU request (level, held until ack)
- `cpu_address`  in  ADDR_W;  `cpu_writedata`  in  DATA_W
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_readdata`  out  DATA_W  registered read result
- `dma_read`, `dma_write`, `dma_address`, `dma_writedata`, `dma_ack`, `dma_readdata`: same as CPU set
- `data_address`  out  ADDR_W;  `data_writedata`  out  DATA_W
- `data_read`, `data_write`  out  1  memory strobes
- `data_readdata`  in  DATA_W  memory read data, valid the cycle after `data_read`

## Operation
- FSM: IDLE → ISSUE → RESP → IDLE. One access per three enabled cycles.
- IDLE: pending = read|write per port. None pending: stay. Otherwise choose the winner, latch grant, address, writedata, and operation into registers, then go to ISSUE.
- Arbitration: CPU wins unless DMA pending and `burst_cnt == MAX_BURST`. DMA alone wins.
- `burst_cnt`: +1 on CPU grant while DMA pending (saturates at MAX_BURST). Cleared on DMA grant or on any arbitration where DMA is not pending.
- read and write both high on one port: treated as write; read ignored.
- ISSUE: drive latched `data_address`/`data_writedata`; assert exactly one of `data_write`/`data_read` for this cycle. Go to RESP.
- RESP: `<granted>_ack` = 1 (combinational from state/grant). On read, capture `data_readdata` into `<granted>_readdata` at the end of RESP. On write, readdata is unchanged. Go to IDLE.
- Requesters keep inputs stable until they sample ack. A request still high in the next IDLE cycle is a new request.
- Outside ISSUE: strobes = 0; `data_address`/`data_writedata` hold last latched value.
- `clk_enable` = 0: state, counter, and latches hold; strobes forced 0; acks forced 0. On re-enable, the frozen state resumes (an ISSUE repeats its strobe).

## Timing
- Reset (async, `reset`=0): state IDLE, `burst_cnt`=0, all acks/strobes 0, `data_address`/`data_writedata`/`cpu_readdata`/`dma_readdata` = 0. Any in-flight access is dropped with no ack.
- Cycle 0: IDLE with req high. Cycle 1: ISSUE, strobe high. Cycle 2: RESP, ack high, readdata valid from cycle 3.
- Request-to-ack latency is 2 cycles. Back-to-back accesses from the same port take 3 cycles each.
- Simultaneous requests: only one port acked per RESP; the loser stays pending, is re-arbitrated at the next IDLE, and is acked 3 cycles later.
- Worst-case DMA wait under continuous CPU load: MAX_BURST CPU accesses, then DMA is granted.

## Test plan
- Reset value check: hold `reset`=0 with random inputs → all outputs 0. Release, with no requests → `data_read`=`data_write`=0 indefinitely.
- CPU read: `cpu_read`=1, `cpu_address`=0x10, memory preloaded 0xDEADBEEF → `data_read`=1 at cycle 1 with `data_address`=0x10; `cpu_ack` at cycle 2; `cpu_readdata`=0xDEADBEEF from cycle 3.
- DMA write then CPU read: DMA writes 0x12345678 to 0x20; afterwards the CPU reads 0x20 → `cpu_readdata`=0x12345678, `dma_ack` pulsed exactly once.
- Contention: both ports request at cycle 0 → CPU acked at cycle 2, DMA at cycle 5. With CPU continuously requesting and MAX_BURST=4 → the fifth grant goes to DMA, then CPU resumes.
- `clk_enable` drop: deassert during ISSUE for 3 cycles → strobes 0 and no ack while low. After re-enable: one strobe, one ack, correct data.
- Reset mid-op: assert `reset` during RESP of a DMA read → no further ack, `dma_readdata`=0. A new CPU write after release completes normally.
